// File: rtl/switch_debouncer.sv
// switch_debouncer
//
// Conditions raw board switch/button levels for the logic-function and LED
// stage. Each channel is synchronised into the 10 MHz clock domain, held
// until it has been stable for DEBOUNCE_CYCLES clocks, and then published as
// a clean level together with single-cycle rise/fall pulses.
//
// Ports:
//   clk_10mhz   system clock (MMCM CLKOUT0)
//   rst         asynchronous, active-high reset
//   din         raw asynchronous switch/button levels, WIDTH bits
//   dout        debounced levels, WIDTH bits
//   rise        one-cycle pulse per channel when dout[i] goes 0->1
//   fall        one-cycle pulse per channel when dout[i] goes 1->0
//   any_change  OR of all rise/fall bits, registered with them

module switch_debouncer #(
    parameter int   WIDTH           = 5,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 100000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             clk_10mhz,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Last count value before a new level is accepted; the accepting cycle
    // itself is the DEBOUNCE_CYCLES-th consecutive mismatching clock.
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the structure below cannot honour.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("switch_debouncer: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES must be in 1..2^24");
    end

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    logic [WIDTH-1:0] s_sync;
    logic [CW-1:0]    count_q [WIDTH];
    logic [CW-1:0]    count_d [WIDTH];
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    assign s_sync = sync_q[SYNC_STAGES-1];

    // Plain shift chain with nothing between stages so that only the first
    // stage can ever go metastable.
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {WIDTH{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel stability counter. Any cycle where the synchronised input
    // agrees with the published level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing cycles changes dout. The
    // count is reset on acceptance, so it can never pass TERMINAL.
    always_comb begin
        dout_d = dout;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = count_q[i];
            if (s_sync[i] == dout[i]) begin
                count_d[i] = '0;
            end else if (count_q[i] == TERMINAL) begin
                count_d[i] = '0;
                dout_d[i]  = s_sync[i];
                rise_d[i]  = s_sync[i];
                fall_d[i]  = ~s_sync[i];
            end else begin
                count_d[i] = count_q[i] + CW'(1);
            end
        end
    end

    // Level, pulses and counters all register together; pulses default low
    // so each lasts exactly one clock.
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            dout       <= {WIDTH{RESET_LEVEL}};
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            dout       <= dout_d;
            rise       <= rise_d;
            fall       <= fall_d;
            any_change <= |(rise_d | fall_d);
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//
// Directed bench for switch_debouncer. Instance dut uses DEBOUNCE_CYCLES=8,
// RESET_LEVEL=0; instance dut_b uses DEBOUNCE_CYCLES=1, RESET_LEVEL=1.
// Inputs change on the falling edge; outputs are compared on the falling edge
// following each rising edge.

module tb_switch_debouncer;

    localparam int W = 5;

    logic         clk_10mhz = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;

    logic         rst_b;
    logic [W-1:0] din_b;
    logic [W-1:0] dout_b;
    logic [W-1:0] rise_b;
    logic [W-1:0] fall_b;
    logic         any_change_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         any;
        string        name;
    } vec_t;

    vec_t vecs[$];

    switch_debouncer #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk_10mhz  (clk_10mhz),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    switch_debouncer #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_LEVEL     (1'b1)
    ) dut_b (
        .clk_10mhz  (clk_10mhz),
        .rst        (rst_b),
        .din        (din_b),
        .dout       (dout_b),
        .rise       (rise_b),
        .fall       (fall_b),
        .any_change (any_change_b)
    );

    // 10 MHz clock
    always #50 clk_10mhz = ~clk_10mhz;

    // Safety net in case the sequence below ever stalls
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic [W-1:0] d, input logic [W-1:0] o,
                          input logic [W-1:0] r, input logic [W-1:0] f,
                          input logic a, input string n);
        vec_t v;
        v.din  = d;
        v.dout = o;
        v.rise = r;
        v.fall = f;
        v.any  = a;
        v.name = n;
        vecs.push_back(v);
    endtask

    // n quiet cycles: constant din, constant dout, no pulses
    task automatic addHold(input logic [W-1:0] d, input logic [W-1:0] o,
                           input int n, input string name);
        for (int k = 0; k < n; k++) begin
            addVec(d, o, '0, '0, 1'b0, name);
        end
    endtask

    // Drive din at a falling edge and advance to the next falling edge
    task automatic applyStimulus(input logic [W-1:0] d);
        din = d;
        @(posedge clk_10mhz);
        @(negedge clk_10mhz);
    endtask

    task automatic applyStimulusB(input logic [W-1:0] d);
        din_b = d;
        @(posedge clk_10mhz);
        @(negedge clk_10mhz);
    endtask

    task automatic checkOutput(input string name,
                               input logic [W-1:0] ad, input logic [W-1:0] ar,
                               input logic [W-1:0] af, input logic aa,
                               input logic [W-1:0] ed, input logic [W-1:0] er,
                               input logic [W-1:0] ef, input logic ea);
        checks++;
        if ({ad, ar, af, aa} !== {ed, er, ef, ea}) begin
            failures++;
            $display("[TB] FAIL %s: got dout=%b rise=%b fall=%b any=%b, expected dout=%b rise=%b fall=%b any=%b",
                     name, ad, ar, af, aa, ed, er, ef, ea);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        rst   = 1'b1;
        din   = '0;
        rst_b = 1'b1;
        din_b = 5'b11111;

        // Clean edge on channel 0: latency 10 edges
        addHold(5'b00001, 5'b00000, 9, "clean_wait");
        addVec (5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b1, "clean_rise");
        addHold(5'b00001, 5'b00001, 2, "clean_after");
        // Glitch on channel 2: 7 cycles is one short of acceptance
        addHold(5'b00101, 5'b00001, 7, "glitch_high");
        addHold(5'b00001, 5'b00001, 5, "glitch_low");
        // Bounce on channel 1 in 3-cycle segments, then a steady 1
        addHold(5'b00011, 5'b00001, 3, "bounce_seg1");
        addHold(5'b00001, 5'b00001, 3, "bounce_seg2");
        addHold(5'b00011, 5'b00001, 3, "bounce_seg3");
        addHold(5'b00001, 5'b00001, 3, "bounce_seg4");
        addHold(5'b00011, 5'b00001, 9, "bounce_hold");
        addVec (5'b00011, 5'b00011, 5'b00010, 5'b00000, 1'b1, "bounce_rise");
        addHold(5'b00011, 5'b00011, 2, "bounce_after");
        // Channels 3 and 4 rise together, then fall together
        addHold(5'b11011, 5'b00011, 9, "pair_rise_wait");
        addVec (5'b11011, 5'b11011, 5'b11000, 5'b00000, 1'b1, "pair_rise");
        addHold(5'b11011, 5'b11011, 2, "pair_rise_after");
        addHold(5'b00011, 5'b11011, 9, "pair_fall_wait");
        addVec (5'b00011, 5'b00011, 5'b00000, 5'b11000, 1'b1, "pair_fall");
        addHold(5'b00011, 5'b00011, 2, "pair_fall_after");

        repeat (2) @(negedge clk_10mhz);
        checkOutput("reset_state", dout, rise, fall, any_change,
                    5'b00000, 5'b00000, 5'b00000, 1'b0);
        checkValue("reset_count0", int'(dut.count_q[0]), 0);
        checkOutput("b_reset_state", dout_b, rise_b, fall_b, any_change_b,
                    5'b11111, 5'b00000, 5'b00000, 1'b0);

        rst = 1'b0;
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].din);
            checkOutput(vecs[k].name, dout, rise, fall, any_change,
                        vecs[k].dout, vecs[k].rise, vecs[k].fall, vecs[k].any);
        end

        // Channel 0 starts debouncing a fall; reset hits with count at 5
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(5'b00010);
            checkOutput("midcount_hold", dout, rise, fall, any_change,
                        5'b00011, 5'b00000, 5'b00000, 1'b0);
        end
        checkValue("midcount_count", int'(dut.count_q[0]), 5);

        #20;
        rst = 1'b1;
        din = 5'b00001;
        #1;
        checkOutput("async_reset", dout, rise, fall, any_change,
                    5'b00000, 5'b00000, 5'b00000, 1'b0);
        checkValue("async_reset_count", int'(dut.count_q[0]), 0);
        @(negedge clk_10mhz);
        @(negedge clk_10mhz);
        checkOutput("reset_held", dout, rise, fall, any_change,
                    5'b00000, 5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;

        // After release, held din[0]=1 rises on edge 10
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(5'b00001);
            checkOutput("post_reset", dout, rise, fall, any_change,
                        (k >= 10) ? 5'b00001 : 5'b00000,
                        (k == 10) ? 5'b00001 : 5'b00000,
                        5'b00000, (k == 10));
        end

        // DEBOUNCE_CYCLES=1, RESET_LEVEL=1 instance
        rst_b = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            applyStimulusB(5'b11111);
            checkOutput("b_idle", dout_b, rise_b, fall_b, any_change_b,
                        5'b11111, 5'b00000, 5'b00000, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            applyStimulusB(5'b11110);
            checkOutput("b_fall", dout_b, rise_b, fall_b, any_change_b,
                        (k >= 3) ? 5'b11110 : 5'b11111,
                        5'b00000,
                        (k == 3) ? 5'b00001 : 5'b00000, (k == 3));
        end
        for (int k = 1; k <= 4; k++) begin
            applyStimulusB(5'b11111);
            checkOutput("b_rise", dout_b, rise_b, fall_b, any_change_b,
                        (k >= 3) ? 5'b11111 : 5'b11110,
                        (k == 3) ? 5'b00001 : 5'b00000,
                        5'b00000, (k == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw board switch/button inputs before they reach the logic-function and LED stage.
- Per channel, it first synchronises the raw input into the 10 MHz MMCM clock domain.
- It then rejects contact bounce and publishes a clean level plus single-cycle rise/fall pulses.
- Its outputs feed the downstream combinational logic (AND/OR/NOT of the inputs) in place of the raw pins.

Parameters:
- WIDTH, 5, number of independent input channels.
- SYNC_STAGES, 2, flip-flops in each channel's synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 100000, consecutive stable clocks required to accept a new level (10 ms at 10 MHz); legal range 1..2^24.
- RESET_LEVEL, 1'b0, value loaded into synchronisers and debounced outputs on reset.

Ports:
- clk_10mhz  input  1  system clock from the MMCM CLKOUT0.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  raw asynchronous switch/button levels.
- dout  output  WIDTH  debounced levels.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1->0.
- any_change  output  1  OR-reduction of (rise | fall), registered together with them.

Behaviour:
- Reset (async assert, sync-released by the clock tree upstream):
  - every synchroniser FF = RESET_LEVEL; dout = {WIDTH{RESET_LEVEL}};
  - all counters = 0; rise = fall = 0; any_change = 0.
- Synchroniser: din[i] is sampled into stage 1 each rising edge and shifts through SYNC_STAGES FFs. s[i] is the last stage. No logic sits between stages.
- Counter per channel: width = $clog2(DEBOUNCE_CYCLES+1), unsigned.
  - If s[i] == dout[i]: counter clears to 0.
  - If s[i] != dout[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s[i] != dout[i] and counter == DEBOUNCE_CYCLES-1: dout[i] <= s[i], counter <= 0, and rise[i]/fall[i] <= 1 according to direction.
  - Any single cycle with s[i] == dout[i] restarts the count, so a bounce shorter than DEBOUNCE_CYCLES never reaches dout.
  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Latency: number rising edges from the first edge that samples the new din level as edge 1. dout[i], and the matching pulse, update on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulses:
  - rise, fall and any_change are registered and high for exactly one clock.
  - Default is 0 every cycle.
  - rise[i] and fall[i] are never high together.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle, and any_change is a single 1.
- DEBOUNCE_CYCLES = 1 degenerates to synchroniser plus one register stage: dout follows s with one clock of delay.
- Reset mid-count: the partial count is discarded and dout returns to RESET_LEVEL with no pulse.
  - After release, a din held opposite to RESET_LEVEL debounces normally.
  - That transition produces one rise (or fall) pulse; this is intended and lets downstream see the power-up switch state.
- din is treated as fully asynchronous. Only stage 1 may go metastable; the synchroniser FFs carry ASYNC_REG.
- No combinational path from din to any output.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=5, RESET_LEVEL=0 unless stated):
- Clean edge: din[0] 0->1 held → dout[0]=1 and rise[0]=1 for one cycle on edge 10; other channels stay 0; any_change=1 in the same cycle only.
- Bounce rejection: din[1] toggles 1,0,1,0 with 3-cycle segments, then holds 1.
  - No dout change during the bounce.
  - dout[1] rises exactly 10 edges after the final 0->1 sample.
  - Exactly one rise pulse.
- Glitch: din[2]=1 for 7 cycles then back to 0 → dout[2] stays 0; rise/fall stay 0 throughout.
- Release and simultaneous channels: din[3] and din[4] both 1->0 on the same edge after being debounced high → fall[3] and fall[4] in the same cycle; any_change=1 for one cycle.
- Async reset mid-count: assert rst on a non-clock-aligned time with counter[0]=5 → dout=0, counter=0, no pulse.
  - With din[0]=1 held after release, rise[0] occurs 10 edges after the first post-release edge.
- DEBOUNCE_CYCLES=1, RESET_LEVEL=1:
  - After reset, dout=5'b11111.
  - din[0] 1->0 → dout[0]=0 and fall[0]=1 on edge 3.
